// File: rtl/div_pkg.sv
// Shared types and constants for the iterative integer divider.
// The divide-by-zero quotient is built from the operand width at elaboration.
package div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   localparam int DIV_MAX_W = 128;

   function automatic logic [DIV_MAX_W-1:0] dbz_quot(input int width);
      logic [DIV_MAX_W-1:0] v;
      v = '0;
      for (int i = 0; i < DIV_MAX_W; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: compare/subtract a (WIDTH+1)-bit
// partial remainder against the divisor, yielding the next remainder and one quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   pr_in,
   input  logic [WIDTH-1:0] dvsr,
   output logic [WIDTH-1:0] pr_out,
   output logic             q_bit
);

   assign q_bit = (pr_in >= {1'b0, dvsr});
   // The true difference is below dvsr, so WIDTH-bit modular arithmetic is exact.
   assign pr_out = pr_in[WIDTH-1:0] - (q_bit ? dvsr : '0);

endmodule

// File: rtl/idiv_unit.sv
// Signed/unsigned iterative divider: WIDTH/BITS_PER_CYCLE cycles per result, one cycle for divide-by-zero.
// One operation in flight; result held in DONE until out_ready, flush aborts from any state.
module idiv_unit
   import div_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             div_clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic [WIDTH-1:0] out_r,
   output logic             out_dbz,
   output logic             busy
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]        CNT_N    = CW'(N);
   localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
   localparam logic [DIV_MAX_W-1:0] DBZ_FULL = dbz_quot(WIDTH);
   localparam logic [WIDTH-1:0]     DBZ_Q    = DBZ_FULL[WIDTH-1:0];

   if (WIDTH < 4 || (WIDTH % 2) != 0 || WIDTH > DIV_MAX_W ||
       !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
       (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_params
      $error("idiv_unit: illegal WIDTH/BITS_PER_CYCLE combination");
   end

   div_state_e       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             sgn_q, sgn_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic             x_neg, y_neg, y_zero;
   logic [WIDTH-1:0] x_mag, y_mag;

   assign x_neg  = in_x[WIDTH-1] & in_signed;
   assign y_neg  = in_y[WIDTH-1] & in_signed;
   assign x_mag  = x_neg ? -in_x : in_x;
   assign y_mag  = y_neg ? -in_y : in_y;
   assign y_zero = (in_y == '0);
   assign accept = in_valid & in_ready & ~flush;

   // quo_q starts as the dividend magnitude and shifts quotient bits in from the bottom.
   logic [BITS_PER_CYCLE:0][WIDTH-1:0] rem_c;
   logic [BITS_PER_CYCLE:0][WIDTH-1:0] quo_c;
   logic [BITS_PER_CYCLE-1:0]          qbit;

   assign rem_c[0] = rem_q;
   assign quo_c[0] = quo_q;

   for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_chain
      div_step #(.WIDTH(WIDTH)) u_step (
         .pr_in  ({rem_c[k], quo_c[k][WIDTH-1]}),
         .dvsr   (dvsr_q),
         .pr_out (rem_c[k+1]),
         .q_bit  (qbit[k])
      );
      assign quo_c[k+1] = {quo_c[k][WIDTH-2:0], qbit[k]};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sgn_d   = in_signed;
               qneg_d  = x_neg ^ y_neg;
               rneg_d  = x_neg;
               dbz_d   = y_zero;
               // On divide-by-zero the remainder path re-signs |x|, reproducing the dividend.
               rem_d   = y_zero ? x_mag : '0;
               quo_d   = x_mag;
               dvsr_d  = y_mag;
               cnt_d   = CNT_N;
               state_d = y_zero ? ST_DONE : ST_CALC;
            end
         end
         ST_CALC: begin
            rem_d = rem_c[BITS_PER_CYCLE];
            quo_d = quo_c[BITS_PER_CYCLE];
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge div_clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign out_q     = dbz_q ? DBZ_Q : ((sgn_q & qneg_q) ? -quo_q : quo_q);
   assign out_r     = (sgn_q & rneg_q) ? -rem_q : rem_q;
   assign out_dbz   = dbz_q;

endmodule

// File: tb/tb_idiv_unit.sv
// Bench for idiv_unit: one instance at 1 bit/cycle and one at 2 bits/cycle share the stimulus,
// and results are checked against plain integer arithmetic.
module tb_idiv_unit;

   localparam int W   = 32;
   localparam int N_A = 32;
   localparam int N_B = 16;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   logic         div_clk = 1'b0;
   logic         resetn = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_signed = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] in_x = '0;
   logic [W-1:0] in_y = '0;

   logic         in_ready_a, out_valid_a, out_dbz_a, busy_a;
   logic [W-1:0] out_q_a, out_r_a;
   logic         in_ready_b, out_valid_b, out_dbz_b, busy_b;
   logic [W-1:0] out_q_b, out_r_b;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           obs_lat [2];
   logic [W-1:0] obs_q [2];
   logic [W-1:0] obs_r [2];
   logic         obs_dbz [2];

   always #5 div_clk = ~div_clk;

   idiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut_a (
      .div_clk(div_clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_signed(in_signed),
      .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_q(out_q_a), .out_r(out_r_a), .out_dbz(out_dbz_a), .busy(busy_a)
   );

   idiv_unit #(.WIDTH(W), .BITS_PER_CYCLE(2)) u_dut_b (
      .div_clk(div_clk), .resetn(resetn), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_signed(in_signed),
      .in_x(in_x), .in_y(in_y),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_q(out_q_b), .out_r(out_r_b), .out_dbz(out_dbz_b), .busy(busy_b)
   );

   // Reference: C-style truncating division on 64-bit integers.
   task automatic ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dbz);
      longint xs, ys;
      if (y == '0) begin
         q = 32'hFFFF_FFFF;
         r = x;
         dbz = 1'b1;
      end else begin
         dbz = 1'b0;
         if (s) begin
            xs = longint'($signed(x));
            ys = longint'($signed(y));
            q  = 32'(xs / ys);
            r  = 32'(xs % ys);
         end else begin
            q = x / y;
            r = x % y;
         end
      end
   endtask

   task automatic step();
      @(posedge div_clk);
      #1;
   endtask

   // Present one request with out_ready high; record each unit's first result and its cycle index.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      bit got [2];
      for (int d = 0; d < 2; d++) begin
         got[d] = 1'b0;
         obs_lat[d] = -1;
         obs_q[d] = '0;
         obs_r[d] = '0;
         obs_dbz[d] = 1'b0;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 100 && !(in_ready_a && in_ready_b); k++) step();
      in_x = x;
      in_y = y;
      in_signed = s;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= 100 && !(got[0] && got[1]); c++) begin
         if (!got[0] && out_valid_a) begin
            got[0] = 1'b1; obs_lat[0] = c; obs_q[0] = out_q_a; obs_r[0] = out_r_a; obs_dbz[0] = out_dbz_a;
         end
         if (!got[1] && out_valid_b) begin
            got[1] = 1'b1; obs_lat[1] = c; obs_q[1] = out_q_b; obs_r[1] = out_r_b; obs_dbz[1] = out_dbz_b;
         end
         step();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      in_valid = 1'b1;
      flush = 1'b1;
      in_x = 32'd77;
      in_y = 32'd5;
      step();
      step();
      n_cmp += 12;
      if (in_ready_a !== 1'b1)  begin n_bad++; $display("FAIL reset in_ready_a: got %b want 1", in_ready_a); end
      if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset out_valid_a: got %b want 0", out_valid_a); end
      if (busy_a !== 1'b0)      begin n_bad++; $display("FAIL reset busy_a: got %b want 0", busy_a); end
      if (out_q_a !== '0)       begin n_bad++; $display("FAIL reset out_q_a: got %h want 0", out_q_a); end
      if (out_r_a !== '0)       begin n_bad++; $display("FAIL reset out_r_a: got %h want 0", out_r_a); end
      if (out_dbz_a !== 1'b0)   begin n_bad++; $display("FAIL reset out_dbz_a: got %b want 0", out_dbz_a); end
      if (in_ready_b !== 1'b1)  begin n_bad++; $display("FAIL reset in_ready_b: got %b want 1", in_ready_b); end
      if (out_valid_b !== 1'b0) begin n_bad++; $display("FAIL reset out_valid_b: got %b want 0", out_valid_b); end
      if (busy_b !== 1'b0)      begin n_bad++; $display("FAIL reset busy_b: got %b want 0", busy_b); end
      if (out_q_b !== '0)       begin n_bad++; $display("FAIL reset out_q_b: got %h want 0", out_q_b); end
      if (out_r_b !== '0)       begin n_bad++; $display("FAIL reset out_r_b: got %h want 0", out_r_b); end
      if (out_dbz_b !== 1'b0)   begin n_bad++; $display("FAIL reset out_dbz_b: got %b want 0", out_dbz_b); end
      in_valid = 1'b0;
      flush = 1'b0;
      resetn = 1'b1;
      step();
   endtask

   task automatic test_arith();
      vec_t vecs [$];
      vec_t v;
      int   sel;
      int   exp_lat;
      vecs.push_back('{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0});
      vecs.push_back('{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0});
      vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0});
      vecs.push_back('{32'h12345678,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h12345678,  1'b1});
      vecs.push_back('{32'h80000000,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h80000000,  1'b1});
      vecs.push_back('{32'hFFFFFFFF,  32'd3,         1'b0, 32'h55555555,  32'd0,         1'b0});
      vecs.push_back('{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0});
      vecs.push_back('{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         1'b0});
      vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'd1,         32'd0,         1'b0});
      vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 32'd1,         32'd0,         1'b0});
      for (int i = 0; i < 50; i++) begin
         sel = $urandom_range(0, 7);
         v.x = $urandom;
         v.y = $urandom;
         v.s = 1'($urandom_range(0, 1));
         if (sel == 0) v.y = '0;
         if (sel == 1) v.y = $urandom_range(1, 15);
         if (sel == 2) v.y = -32'($urandom_range(1, 15));
         if (sel == 3) v.x = 32'h80000000;
         ref_div(v.x, v.y, v.s, v.q, v.r, v.dbz);
         vecs.push_back(v);
      end
      for (int i = 0; i < vecs.size(); i++) begin
         run_op(vecs[i].x, vecs[i].y, vecs[i].s);
         for (int d = 0; d < 2; d++) begin
            exp_lat = vecs[i].dbz ? 1 : ((d == 0) ? N_A + 1 : N_B + 1);
            n_cmp += 4;
            if (obs_q[d] !== vecs[i].q) begin
               n_bad++; $display("FAIL arith[%0d] dut%0d q: got %h want %h", i, d, obs_q[d], vecs[i].q);
            end
            if (obs_r[d] !== vecs[i].r) begin
               n_bad++; $display("FAIL arith[%0d] dut%0d r: got %h want %h", i, d, obs_r[d], vecs[i].r);
            end
            if (obs_dbz[d] !== vecs[i].dbz) begin
               n_bad++; $display("FAIL arith[%0d] dut%0d dbz: got %b want %b", i, d, obs_dbz[d], vecs[i].dbz);
            end
            if (obs_lat[d] != exp_lat) begin
               n_bad++; $display("FAIL arith[%0d] dut%0d latency: got %0d want %0d", i, d, obs_lat[d], exp_lat);
            end
         end
      end
   endtask

   task automatic test_flush();
      int seen;
      out_ready = 1'b1;
      in_x = 32'd1000; in_y = 32'd77; in_signed = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 1; c < 10; c++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp += 4;
      if (in_ready_a !== 1'b1)  begin n_bad++; $display("FAIL flush in_ready_a: got %b want 1", in_ready_a); end
      if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL flush out_valid_a: got %b want 0", out_valid_a); end
      if (in_ready_b !== 1'b1)  begin n_bad++; $display("FAIL flush in_ready_b: got %b want 1", in_ready_b); end
      if (busy_b !== 1'b0)      begin n_bad++; $display("FAIL flush busy_b: got %b want 0", busy_b); end
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         if (out_valid_a || out_valid_b) seen++;
         step();
      end
      n_cmp++;
      if (seen != 0) begin n_bad++; $display("FAIL flush late_valid: got %0d cycles want 0", seen); end
      // flush presented together with a request must suppress the accept
      in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      n_cmp += 2;
      if (busy_a !== 1'b0) begin n_bad++; $display("FAIL flush_vs_accept busy_a: got %b want 0", busy_a); end
      if (busy_b !== 1'b0) begin n_bad++; $display("FAIL flush_vs_accept busy_b: got %b want 0", busy_b); end
      run_op(32'd1000, 32'd10, 1'b0);
      for (int d = 0; d < 2; d++) begin
         n_cmp += 2;
         if (obs_q[d] !== 32'd100) begin n_bad++; $display("FAIL after_flush dut%0d q: got %h want %h", d, obs_q[d], 32'd100); end
         if (obs_r[d] !== 32'd0)   begin n_bad++; $display("FAIL after_flush dut%0d r: got %h want 0", d, obs_r[d]); end
      end
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      in_x = 32'd200; in_y = 32'd3; in_signed = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 60 && !(out_valid_a && out_valid_b); k++) step();
      for (int c = 0; c < 5; c++) begin
         n_cmp += 10;
         if (out_valid_a !== 1'b1)  begin n_bad++; $display("FAIL stall[%0d] out_valid_a: got %b want 1", c, out_valid_a); end
         if (out_q_a !== 32'd66)    begin n_bad++; $display("FAIL stall[%0d] out_q_a: got %h want %h", c, out_q_a, 32'd66); end
         if (out_r_a !== 32'd2)     begin n_bad++; $display("FAIL stall[%0d] out_r_a: got %h want 2", c, out_r_a); end
         if (in_ready_a !== 1'b0)   begin n_bad++; $display("FAIL stall[%0d] in_ready_a: got %b want 0", c, in_ready_a); end
         if (busy_a !== 1'b1)       begin n_bad++; $display("FAIL stall[%0d] busy_a: got %b want 1", c, busy_a); end
         if (out_valid_b !== 1'b1)  begin n_bad++; $display("FAIL stall[%0d] out_valid_b: got %b want 1", c, out_valid_b); end
         if (out_q_b !== 32'd66)    begin n_bad++; $display("FAIL stall[%0d] out_q_b: got %h want %h", c, out_q_b, 32'd66); end
         if (out_r_b !== 32'd2)     begin n_bad++; $display("FAIL stall[%0d] out_r_b: got %h want 2", c, out_r_b); end
         if (in_ready_b !== 1'b0)   begin n_bad++; $display("FAIL stall[%0d] in_ready_b: got %b want 0", c, in_ready_b); end
         if (busy_b !== 1'b1)       begin n_bad++; $display("FAIL stall[%0d] busy_b: got %b want 1", c, busy_b); end
         step();
      end
      // A request offered during the handshake cycle must not be taken.
      out_ready = 1'b1;
      in_x = 32'd5; in_y = 32'd1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp += 4;
      if (in_ready_a !== 1'b1)  begin n_bad++; $display("FAIL handshake in_ready_a: got %b want 1", in_ready_a); end
      if (busy_a !== 1'b0)      begin n_bad++; $display("FAIL handshake busy_a: got %b want 0", busy_a); end
      if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL handshake out_valid_a: got %b want 0", out_valid_a); end
      if (busy_b !== 1'b0)      begin n_bad++; $display("FAIL handshake busy_b: got %b want 0", busy_b); end
      // flush while a result is waiting
      out_ready = 1'b0;
      in_x = 32'd9; in_y = 32'd4; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 60 && !(out_valid_a && out_valid_b); k++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b1;
      n_cmp += 3;
      if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL flush_done out_valid_a: got %b want 0", out_valid_a); end
      if (out_valid_b !== 1'b0) begin n_bad++; $display("FAIL flush_done out_valid_b: got %b want 0", out_valid_b); end
      if (in_ready_a !== 1'b1)  begin n_bad++; $display("FAIL flush_done in_ready_a: got %b want 1", in_ready_a); end
   endtask

   task automatic test_reset_mid();
      int seen;
      out_ready = 1'b1;
      in_x = 32'd12345; in_y = 32'd67; in_signed = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 1; c < 5; c++) step();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      n_cmp += 6;
      if (busy_a !== 1'b0)   begin n_bad++; $display("FAIL rst_calc busy_a: got %b want 0", busy_a); end
      if (out_q_a !== '0)    begin n_bad++; $display("FAIL rst_calc out_q_a: got %h want 0", out_q_a); end
      if (out_r_a !== '0)    begin n_bad++; $display("FAIL rst_calc out_r_a: got %h want 0", out_r_a); end
      if (busy_b !== 1'b0)   begin n_bad++; $display("FAIL rst_calc busy_b: got %b want 0", busy_b); end
      if (out_q_b !== '0)    begin n_bad++; $display("FAIL rst_calc out_q_b: got %h want 0", out_q_b); end
      if (in_ready_b !== 1'b1) begin n_bad++; $display("FAIL rst_calc in_ready_b: got %b want 1", in_ready_b); end
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         if (out_valid_a || out_valid_b) seen++;
         step();
      end
      n_cmp++;
      if (seen != 0) begin n_bad++; $display("FAIL rst_calc late_valid: got %0d cycles want 0", seen); end
      // reset while a divide-by-zero result is held
      out_ready = 1'b0;
      in_x = 32'd50; in_y = 32'd0; in_signed = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp += 1;
      if (out_dbz_a !== 1'b1) begin n_bad++; $display("FAIL rst_done pre out_dbz_a: got %b want 1", out_dbz_a); end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      out_ready = 1'b1;
      n_cmp += 4;
      if (out_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_done out_valid_a: got %b want 0", out_valid_a); end
      if (out_dbz_a !== 1'b0)   begin n_bad++; $display("FAIL rst_done out_dbz_a: got %b want 0", out_dbz_a); end
      if (out_r_a !== '0)       begin n_bad++; $display("FAIL rst_done out_r_a: got %h want 0", out_r_a); end
      if (out_q_b !== '0)       begin n_bad++; $display("FAIL rst_done out_q_b: got %h want 0", out_q_b); end
   endtask

   // Requests held continuously; only the 1-bit unit is scored here.
   task automatic test_back_to_back();
      logic [W-1:0] xs [5], ys [5], eq [5], er [5];
      logic         ss [5], edz;
      int           idx, res_cnt, last_acc;
      logic         acc;
      for (int i = 0; i < 5; i++) begin
         xs[i] = $urandom;
         ys[i] = $urandom_range(1, 1000);
         ss[i] = 1'($urandom_range(0, 1));
         ref_div(xs[i], ys[i], ss[i], eq[i], er[i], edz);
      end
      idx = 0; res_cnt = 0; last_acc = -1;
      out_ready = 1'b1;
      in_x = xs[0]; in_y = ys[0]; in_signed = ss[0]; in_valid = 1'b1;
      for (int cyc = 0; cyc < 400 && res_cnt < 5; cyc++) begin
         acc = in_valid && in_ready_a;
         if (out_valid_a) begin
            n_cmp += 2;
            if (out_q_a !== eq[res_cnt]) begin n_bad++; $display("FAIL b2b[%0d] q: got %h want %h", res_cnt, out_q_a, eq[res_cnt]); end
            if (out_r_a !== er[res_cnt]) begin n_bad++; $display("FAIL b2b[%0d] r: got %h want %h", res_cnt, out_r_a, er[res_cnt]); end
            res_cnt++;
         end
         if (acc) begin
            if (last_acc >= 0) begin
               n_cmp++;
               if (cyc - last_acc != N_A + 2) begin
                  n_bad++; $display("FAIL b2b accept_gap: got %0d want %0d", cyc - last_acc, N_A + 2);
               end
            end
            last_acc = cyc;
            idx++;
         end
         step();
         if (acc) begin
            if (idx < 5) begin
               in_x = xs[idx]; in_y = ys[idx]; in_signed = ss[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      n_cmp++;
      if (res_cnt != 5) begin n_bad++; $display("FAIL b2b results: got %0d want 5", res_cnt); end
      for (int k = 0; k < 60 && (busy_a || busy_b); k++) step();
   endtask

   initial begin
      test_reset();
      test_arith();
      test_flush();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/idiv_unit.md
IDIV_UNIT -- requirements
Module: idiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >=4.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, quotient bits retired per iteration cycle; legal 1, 2, 4; must divide WIDTH.
REQ-003 SHALL have port div_clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port flush  input  1  abort the current operation and discard its result.
REQ-006 SHALL have port in_valid  input  1  request carries valid operands.
REQ-007 SHALL have port in_ready  output  1  unit can accept a request.
REQ-008 SHALL have port in_signed  input  1  two's-complement mode when 1, unsigned when 0.
REQ-009 SHALL have port in_x  input  WIDTH  dividend.
REQ-010 SHALL have port in_y  input  WIDTH  divisor.
REQ-011 SHALL have port out_valid  output  1  result presented.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port out_q  output  WIDTH  quotient.
REQ-014 SHALL have port out_r  output  WIDTH  remainder.
REQ-015 SHALL have port out_dbz  output  1  divisor was zero; qualified by out_valid.
REQ-016 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-018 in_ready SHALL equal (state==IDLE) and SHALL NOT depend combinationally on in_valid.
REQ-019 Accept condition SHALL be in_valid & in_ready & ~flush; on accept the unit SHALL latch in_signed, the operand magnitudes, sign_q = x_neg^y_neg, sign_r = x_neg and dbz = (in_y==0).
REQ-020 x_neg SHALL be in_x[WIDTH-1]&in_signed and y_neg SHALL be in_y[WIDTH-1]&in_signed; magnitudes SHALL be held in WIDTH-bit unsigned form (|MIN| = 2^(WIDTH-1)).
REQ-021 On accept with dbz=0 the FSM SHALL go IDLE->CALC; with dbz=1 it SHALL go IDLE->DONE.
REQ-022 CALC SHALL perform restoring division, BITS_PER_CYCLE steps per cycle, each step compare/subtract a (WIDTH+1)-bit partial remainder against the divisor magnitude.
REQ-023 CALC SHALL last exactly N = WIDTH/BITS_PER_CYCLE cycles, counted by an iteration counter of width clog2(N+1), and then SHALL go to DONE.
REQ-024 out_valid SHALL equal (state==DONE); for an accept at edge T, out_valid SHALL first be high in the cycle after edge T+N+1 (33 cycles at the defaults); for dbz, in the cycle after edge T+1.
REQ-025 out_q SHALL be the quotient negated if sign_q, else the quotient; out_r SHALL be the remainder negated if sign_r, else the remainder.
REQ-026 dbz result SHALL be out_q = all ones and out_r = the dividend as given, with out_dbz=1.
REQ-027 Signed MIN / -1 SHALL give out_q = MIN and out_r = 0, with no special case in the datapath.
REQ-028 In DONE, out_q, out_r and out_dbz SHALL stay stable until out_valid&out_ready; on that handshake the FSM SHALL go to IDLE.
REQ-029 No request SHALL be accepted in the same cycle as a result handshake; the earliest next accept is the cycle after.
REQ-030 flush SHALL send any state to IDLE at the next edge, deassert out_valid, and discard the result; flush SHALL win over a simultaneous accept or out handshake.
REQ-031 In IDLE, out_q, out_r and out_dbz SHALL retain their last values; they have no meaning while out_valid=0.

Reset
REQ-032 With resetn=0 at an edge, the unit SHALL take state=IDLE, counter=0, datapath registers=0; resetn SHALL take priority over flush and over accept.
REQ-033 After reset the outputs SHALL be in_ready=1, out_valid=0, busy=0, out_q=0, out_r=0, out_dbz=0.
REQ-034 Reset asserted mid-CALC or in DONE SHALL discard the operation with no residual output.

Structure
REQ-035 A package div_pkg SHALL hold the FSM state enum and the dbz quotient constant, with that constant generated from WIDTH.
REQ-036 Sub-module div_step SHALL be the combinational single restoring step (partial remainder, divisor -> next remainder, quotient bit), instantiated BITS_PER_CYCLE times in a chain.
REQ-037 Elaboration SHALL fail on an illegal WIDTH/BITS_PER_CYCLE combination.

Verification
REQ-038 Scenario: unsigned 100/7 at the defaults -> q=14, r=2, out_valid exactly 33 cycles after accept.
REQ-039 Scenario: signed 0xFFFFFFF9 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
REQ-040 Scenario: divide 0x12345678 by 0 -> out_dbz=1, q=0xFFFFFFFF, r=0x12345678, out_valid one cycle after the accept edge.
REQ-041 Scenario: flush at cycle 10 of CALC -> out_valid never rises, in_ready=1 next cycle; a following unsigned 1000/10 returns q=100, r=0.
REQ-042 Scenario: out_ready held low 5 cycles in DONE -> out_q/out_r stable, in_ready=0 and busy=1 throughout, IDLE one cycle after the handshake.
REQ-043 Scenario: BITS_PER_CYCLE=2 build, unsigned 0xFFFFFFFF/3 -> q=0x55555555, r=0, latency 17 cycles.
